core_uart_in: RTL and testbench

Serial input stage feeding the integer register file's byte-input port (INE/INDATA). It receives 8N1 UART frames on RXD, buffers complete bytes in a small FIFO and, on a read request from the core's input instruction, delivers exactly one byte as a single-cycle INE pulse with INDATA. The core holds the destination address on WADDR and stalls while BUSY is high.

---
 rtl/core_uart_in_pkg.sv | 14 +
 rtl/core_fifo.sv | 49 ++++
 rtl/core_uart_in.sv | 133 +++++++++++++
 tb/tb_core_uart_in.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/core_uart_in_pkg.sv
// Shared receiver state encodings and default sizing for the UART input stage.
package core_uart_in_pkg;

  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_t;

  localparam int DEF_CLKS_PER_BIT = 868;
  localparam int DEF_FIFO_DEPTH   = 16;

endpackage

// File: rtl/core_fifo.sv
// Synchronous FIFO; dout shows the head entry before the pop that consumes it.
module core_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rptr];

  always_ff @(posedge CLK) begin
    if (do_push) mem[wptr] <= din;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/core_uart_in.sv
// 8N1 UART receiver feeding a byte FIFO; delivers one byte per core read request.
module core_uart_in
  import core_uart_in_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       RXD,
  input  logic       RD_REQ,
  input  logic       ERR_CLR,
  output logic       INE,
  output logic [7:0] INDATA,
  output logic       BUSY,
  output logic       EMPTY,
  output logic       OVERRUN,
  output logic       FRAME_ERR
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  logic            rx_s1, rxs;
  rx_state_t       state;
  logic [CW-1:0]   cnt;
  logic [2:0]      idx;
  logic [7:0]      shreg;
  logic            rx_push, frm_bad;
  logic [7:0]      rx_byte;
  logic            pending, pop;
  logic            fifo_full, fifo_empty;
  logic [7:0]      fifo_dout;
  logic [$clog2(FIFO_DEPTH):0] fifo_cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rx_s1 <= 1'b1;
      rxs   <= 1'b1;
    end else begin
      rx_s1 <= RXD;
      rxs   <= rx_s1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= RX_IDLE;
      cnt     <= '0;
      idx     <= '0;
      shreg   <= '0;
      rx_push <= 1'b0;
      rx_byte <= '0;
      frm_bad <= 1'b0;
    end else begin
      rx_push <= 1'b0;
      frm_bad <= 1'b0;
      case (state)
        RX_IDLE: if (!rxs) begin
          state <= RX_START;
          cnt   <= '0;
        end
        RX_START: begin
          if (cnt == CNT_HALF) begin
            cnt   <= '0;
            idx   <= '0;
            // A start bit that is high again at mid-bit was only a glitch.
            state <= rxs ? RX_IDLE : RX_DATA;
          end else cnt <= cnt + 1'b1;
        end
        RX_DATA: begin
          if (cnt == CNT_FULL) begin
            cnt        <= '0;
            shreg[idx] <= rxs;
            idx        <= idx + 1'b1;
            if (idx == 3'd7) state <= RX_STOP;
          end else cnt <= cnt + 1'b1;
        end
        RX_STOP: begin
          if (cnt == CNT_FULL) begin
            cnt     <= '0;
            rx_push <= rxs;
            rx_byte <= shreg;
            frm_bad <= !rxs;
            state   <= RX_IDLE;
          end else cnt <= cnt + 1'b1;
        end
        default: state <= RX_IDLE;
      endcase
    end
  end

  assign pop = pending && !fifo_empty;

  core_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .CLK   (CLK),
    .RST_N (RST_N),
    .push  (rx_push),
    .pop   (pop),
    .din   (rx_byte),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pending   <= 1'b0;
      INE       <= 1'b0;
      INDATA    <= '0;
      OVERRUN   <= 1'b0;
      FRAME_ERR <= 1'b0;
    end else begin
      INE <= pop;
      if (pop) begin
        INDATA  <= fifo_dout;
        pending <= 1'b0;
      end else if (RD_REQ) begin
        pending <= 1'b1;
      end
      // Setting beats clearing when both land in one cycle.
      if (rx_push && fifo_full && !pop) OVERRUN <= 1'b1;
      else if (ERR_CLR)                 OVERRUN <= 1'b0;
      if (frm_bad)      FRAME_ERR <= 1'b1;
      else if (ERR_CLR) FRAME_ERR <= 1'b0;
    end
  end

  assign BUSY  = pending;
  assign EMPTY = (fifo_cnt == '0);

endmodule

// File: tb/tb_core_uart_in.sv
// Directed bench for core_uart_in at 16 clocks per bit and a 4-byte FIFO.
module tb_core_uart_in;
  localparam int CPB = 16;

  logic       CLK = 1'b0;
  logic       RST_N, RXD, RD_REQ, ERR_CLR;
  logic       INE, BUSY, EMPTY, OVERRUN, FRAME_ERR;
  logic [7:0] INDATA;
  int checks = 0;
  int failures = 0;

  core_uart_in #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .RXD(RXD), .RD_REQ(RD_REQ), .ERR_CLR(ERR_CLR),
    .INE(INE), .INDATA(INDATA), .BUSY(BUSY), .EMPTY(EMPTY),
    .OVERRUN(OVERRUN), .FRAME_ERR(FRAME_ERR)
  );

  always #5 CLK = ~CLK;

  // All stimulus changes and all samples happen at the falling edge.
  task automatic send_byte(input logic [7:0] d, input logic stop_bit);
    RXD = 1'b0;
    repeat (CPB) @(negedge CLK);
    for (int i = 0; i < 8; i++) begin
      RXD = d[i];
      repeat (CPB) @(negedge CLK);
    end
    RXD = stop_bit;
    repeat (CPB) @(negedge CLK);
    RXD = 1'b1;
    repeat (20) @(negedge CLK);
  endtask

  task automatic read_byte(input logic [7:0] exp, input string name);
    RD_REQ = 1'b1;
    @(negedge CLK);
    RD_REQ = 1'b0;
    checks++;
    if (INE !== 1'b0 || BUSY !== 1'b1) begin
      failures++;
      $display("FAIL %s req_cycle: INE=%b BUSY=%b required INE=0 BUSY=1", name, INE, BUSY);
    end
    @(negedge CLK);
    checks++;
    if (INE !== 1'b1 || INDATA !== exp) begin
      failures++;
      $display("FAIL %s strobe: INE=%b INDATA=%h required INE=1 INDATA=%h", name, INE, INDATA, exp);
    end
    @(negedge CLK);
    checks++;
    if (INE !== 1'b0 || BUSY !== 1'b0 || INDATA !== exp) begin
      failures++;
      $display("FAIL %s after: INE=%b BUSY=%b INDATA=%h required 0 0 %h", name, INE, BUSY, INDATA, exp);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({INE, INDATA, BUSY, EMPTY, OVERRUN, FRAME_ERR} !== {1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset: INE=%b INDATA=%h BUSY=%b EMPTY=%b OVR=%b FERR=%b required 0 00 0 1 0 0",
               INE, INDATA, BUSY, EMPTY, OVERRUN, FRAME_ERR);
    end
  endtask

  task automatic test_basic();
    send_byte(8'hA5, 1'b1);
    checks++;
    if (EMPTY !== 1'b0) begin failures++; $display("FAIL basic_pushed: EMPTY=%b required 0", EMPTY); end
    read_byte(8'hA5, "basic");
    checks++;
    if (EMPTY !== 1'b1 || OVERRUN !== 1'b0 || FRAME_ERR !== 1'b0) begin
      failures++;
      $display("FAIL basic_flags: EMPTY=%b OVR=%b FERR=%b required 1 0 0", EMPTY, OVERRUN, FRAME_ERR);
    end
  endtask

  task automatic test_pending();
    int n_ine = 0, busy_lost = 0, ine_cyc = -1;
    logic [7:0] got = 8'h00;
    logic empty_at_ine = 1'b0;
    RD_REQ = 1'b1;
    @(negedge CLK);
    RD_REQ = 1'b0;
    repeat (3) @(negedge CLK);
    checks++;
    if (BUSY !== 1'b1 || INE !== 1'b0) begin
      failures++;
      $display("FAIL pend_wait: BUSY=%b INE=%b required 1 0", BUSY, INE);
    end
    fork
      send_byte(8'h3C, 1'b1);
      for (int i = 0; i < 200; i++) begin
        @(negedge CLK);
        if (INE) begin
          n_ine++; got = INDATA; ine_cyc = i; empty_at_ine = EMPTY;
        end else if (n_ine == 0 && !BUSY) busy_lost++;
      end
    join
    checks++;
    if (n_ine != 1 || got !== 8'h3C || busy_lost != 0) begin
      failures++;
      $display("FAIL pend_deliver: pulses=%0d data=%h busy_lost=%0d required 1 3c 0", n_ine, got, busy_lost);
    end
    checks++;
    if (ine_cyc < 145 || ine_cyc > 175 || empty_at_ine !== 1'b1) begin
      failures++;
      $display("FAIL pend_timing: ine_cycle=%0d EMPTY=%b required 145..175 and 1", ine_cyc, empty_at_ine);
    end
    checks++;
    if (BUSY !== 1'b0 || EMPTY !== 1'b1) begin
      failures++;
      $display("FAIL pend_after: BUSY=%b EMPTY=%b required 0 1", BUSY, EMPTY);
    end
  endtask

  task automatic test_overrun();
    for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
    checks++;
    if (OVERRUN !== 1'b1 || EMPTY !== 1'b0 || FRAME_ERR !== 1'b0) begin
      failures++;
      $display("FAIL ovr_set: OVR=%b EMPTY=%b FERR=%b required 1 0 0", OVERRUN, EMPTY, FRAME_ERR);
    end
    for (int i = 1; i <= 4; i++) read_byte(8'(i), "ovr_read");
    checks++;
    if (EMPTY !== 1'b1) begin failures++; $display("FAIL ovr_empty: EMPTY=%b required 1", EMPTY); end
    ERR_CLR = 1'b1;
    @(negedge CLK);
    ERR_CLR = 1'b0;
    checks++;
    if (OVERRUN !== 1'b0) begin failures++; $display("FAIL ovr_clr: OVR=%b required 0", OVERRUN); end
  endtask

  task automatic test_frame_err();
    send_byte(8'h55, 1'b0);
    repeat (20) @(negedge CLK);
    checks++;
    if (FRAME_ERR !== 1'b1 || EMPTY !== 1'b1 || OVERRUN !== 1'b0) begin
      failures++;
      $display("FAIL ferr_set: FERR=%b EMPTY=%b OVR=%b required 1 1 0", FRAME_ERR, EMPTY, OVERRUN);
    end
    ERR_CLR = 1'b1;
    @(negedge CLK);
    ERR_CLR = 1'b0;
    checks++;
    if (FRAME_ERR !== 1'b0) begin failures++; $display("FAIL ferr_clr: FERR=%b required 0", FRAME_ERR); end
  endtask

  task automatic test_glitch();
    RXD = 1'b0;
    repeat (3) @(negedge CLK);
    RXD = 1'b1;
    repeat (40) @(negedge CLK);
    checks++;
    if (EMPTY !== 1'b1 || FRAME_ERR !== 1'b0 || OVERRUN !== 1'b0) begin
      failures++;
      $display("FAIL glitch: EMPTY=%b FERR=%b OVR=%b required 1 0 0", EMPTY, FRAME_ERR, OVERRUN);
    end
    send_byte(8'h81, 1'b1);
    read_byte(8'h81, "glitch_next");
  endtask

  task automatic test_reset_mid();
    send_byte(8'h11, 1'b1);
    RXD = 1'b0;
    repeat (CPB) @(negedge CLK);
    RXD = 1'b1;
    repeat (3 * CPB) @(negedge CLK);
    RST_N = 1'b0;
    @(negedge CLK);
    test_reset();
    RXD = 1'b1;
    repeat (5) @(negedge CLK);
    RST_N = 1'b1;
    repeat (10 * CPB) @(negedge CLK);
    checks++;
    if (EMPTY !== 1'b1 || FRAME_ERR !== 1'b0) begin
      failures++;
      $display("FAIL rstmid_quiet: EMPTY=%b FERR=%b required 1 0", EMPTY, FRAME_ERR);
    end
    send_byte(8'h7E, 1'b1);
    read_byte(8'h7E, "rstmid");
    checks++;
    if (EMPTY !== 1'b1) begin failures++; $display("FAIL rstmid_one: EMPTY=%b required 1", EMPTY); end
  endtask

  initial begin
    RST_N = 1'b0; RXD = 1'b1; RD_REQ = 1'b0; ERR_CLR = 1'b0;
    repeat (3) @(negedge CLK);
    test_reset();
    RST_N = 1'b1;
    repeat (5) @(negedge CLK);
    test_basic();
    test_pending();
    test_overrun();
    test_frame_err();
    test_glitch();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
